// File: rtl/fibonacci_bcd_display_if.sv
// Sample handshake between the series generator and the BCD display.
// The master drives value/valid; the slave answers with ready.
interface fibonacci_bcd_display_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_value;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_value,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_value,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fibonacci_bcd_display.sv
// Binary-to-BCD (double-dabble) converter feeding a multiplexed
// active-low seven-segment display with leading-zero blanking.
module fibonacci_bcd_display #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fibonacci_bcd_display_if.slave in_bus,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [WIDTH-1:0]    sr;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt;
  logic                accept;

  assign in_bus.in_ready = (state == IDLE);
  assign accept = in_bus.in_valid && (state == IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_bus.in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Nibbles >= 5 become >= 8 after +3, so the shift carries into the next digit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr        <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      if (accept) begin
        sr      <= in_bus.in_value;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        scratch <= {adj[4*DIGITS-2:0], sr[WIDTH-1]};
        sr      <= sr << 1;
        cnt     <= cnt - CW'(1);
      end else if (state == DONE) begin
        bcd_out <= scratch;
      end
    end
  end

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic              tc;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] an_nx;
  logic [3:0]        nib;
  logic              nib_blank;
  logic              zero_above;
  logic [6:0]        seg_nx;

  assign tc = (pre == PW'(SCAN_DIV - 1));

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (bcd_out[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
    nib       = '0;
    nib_blank = 1'b0;
    an_nx     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = bcd_out[4*i +: 4];
        nib_blank = blank[i];
        an_nx[i]  = 1'b0;
      end
    end
    seg_nx = decode(nib);
    if ((BLANK_LZ != 0) && nib_blank) seg_nx = 7'h7F;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre   <= '0;
      idx   <= '0;
      an_n  <= '1;
      seg_n <= 7'h7F;
    end else if (tc) begin
      pre   <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      an_n  <= an_nx;
      seg_n <= seg_nx;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: tb/tb_fibonacci_bcd_display.sv
// Directed bench for fibonacci_bcd_display: conversion timing,
// drop-while-busy, reset abort and display scan/blanking.
module tb_fibonacci_bcd_display;

  localparam int W = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fibonacci_bcd_display_if #(.WIDTH(W)) bus ();
  fibonacci_bcd_display_if #(.WIDTH(W)) bus_b ();

  assign bus_b.in_value = bus.in_value;
  assign bus_b.in_valid = bus.in_valid;

  logic [4*D-1:0] bcd_a, bcd_b;
  logic           valid_a, valid_b;
  logic [6:0]     seg_a, seg_b;
  logic [D-1:0]   an_a, an_b;

  fibonacci_bcd_display #(
    .WIDTH(W), .DIGITS(D), .SCAN_DIV(4), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_bus(bus),
    .bcd_out(bcd_a), .bcd_valid(valid_a),
    .seg_n(seg_a), .an_n(an_a)
  );

  fibonacci_bcd_display #(
    .WIDTH(W), .DIGITS(D), .SCAN_DIV(4), .BLANK_LZ(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .in_bus(bus_b),
    .bcd_out(bcd_b), .bcd_valid(valid_b),
    .seg_n(seg_b), .an_n(an_b)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic conv(input logic [W-1:0] v,
                      output int lat, output int low);
    bus.in_value = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    low = 0;
    while (!valid_a && lat < 40) begin
      if (!bus.in_ready) low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic scan_sync();
    int n;
    n = 0;
    while (an_a == 5'b11110 && n < 40) begin
      @(negedge clk); n++;
    end
    while (an_a != 5'b11110 && n < 40) begin
      @(negedge clk); n++;
    end
    check("scan_sync", 32'(n < 40), 32'd1);
  endtask

  int lat, low, t0, t1, cnt, k;
  logic [4*D-1:0] res [3];

  initial begin
    bus.in_value = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_bcd",   32'(bcd_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_an",    32'(an_a), 32'h1F);
    check("rst_seg",   32'(seg_a), 32'h7F);
    reset_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("dark_an", 32'(an_a), 32'h1F);
      check("dark_seg", 32'(seg_a), 32'h7F);
    end
    @(negedge clk);
    check("z_an0",   32'(an_a), 32'h1E);
    check("z_seg0",  32'(seg_a), 32'h40);
    check("z_segb0", 32'(seg_b), 32'h40);
    for (int d = 1; d < D; d++) begin
      repeat (4) @(negedge clk);
      check("z_an",   32'(an_a), 32'(~(5'b1 << d) & 5'h1F));
      check("z_anb",  32'(an_b), 32'(~(5'b1 << d) & 5'h1F));
      check("z_seg",  32'(seg_a), 32'h7F);
      check("z_segb", 32'(seg_b), 32'h40);
    end

    conv(16'd46368, lat, low);
    check("c1_lat",   32'(lat), 32'd17);
    check("c1_low",   32'(low), 32'd17);
    check("c1_bcd",   32'(bcd_a), 32'h46368);
    check("c1_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("c1_pulse", 32'(valid_a), 32'd0);

    conv(16'd0, lat, low);
    t0 = cyc;
    check("c2_bcd", 32'(bcd_a), 32'h0);
    conv(16'd65535, lat, low);
    t1 = cyc;
    check("c3_bcd",     32'(bcd_a), 32'h65535);
    check("c3_spacing", 32'(t1 - t0), 32'd18);
    @(negedge clk);

    cnt = 0;
    for (int i = 0; i <= 60; i++) begin
      if (valid_a) begin
        if (cnt < 3) res[cnt] = bcd_a;
        cnt++;
      end
      bus.in_value = 16'(i);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("inc_count", 32'(cnt), 32'd3);
    check("inc_r0", 32'(res[0]), 32'h00000);
    check("inc_r1", 32'(res[1]), 32'h00018);
    check("inc_r2", 32'(res[2]), 32'h00036);
    repeat (20) @(negedge clk);
    check("inc_last", 32'(bcd_a), 32'h00054);

    bus.in_value = 16'd1597;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("ab_ready", 32'(bus.in_ready), 32'd1);
    check("ab_bcd",   32'(bcd_a), 32'd0);
    check("ab_valid", 32'(valid_a), 32'd0);
    check("ab_an",    32'(an_a), 32'h1F);
    check("ab_seg",   32'(seg_a), 32'h7F);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_a) k++;
    end
    check("ab_nopulse", 32'(k), 32'd0);
    conv(16'd1597, lat, low);
    check("ab_lat", 32'(lat), 32'd17);
    check("ab_bcd2", 32'(bcd_a), 32'h01597);
    @(negedge clk);

    conv(16'd144, lat, low);
    check("s_bcd", 32'(bcd_a), 32'h00144);
    scan_sync();
    check("s_seg0", 32'(seg_a), 32'h19);
    repeat (2) @(negedge clk);
    check("s_hold", 32'(an_a), 32'h1E);
    repeat (2) @(negedge clk);
    check("s_an1",  32'(an_a), 32'h1D);
    check("s_seg1", 32'(seg_a), 32'h19);
    repeat (4) @(negedge clk);
    check("s_an2",  32'(an_a), 32'h1B);
    check("s_seg2", 32'(seg_a), 32'h79);
    repeat (4) @(negedge clk);
    check("s_an3",   32'(an_a), 32'h17);
    check("s_seg3",  32'(seg_a), 32'h7F);
    check("s_segb3", 32'(seg_b), 32'h40);
    repeat (4) @(negedge clk);
    check("s_an4",  32'(an_a), 32'h0F);
    check("s_seg4", 32'(seg_a), 32'h7F);
    repeat (4) @(negedge clk);
    check("s_wrap", 32'(an_a), 32'h1E);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fibonacci_bcd_display.md
# fibonacci_bcd_display

Downstream consumer of the Fibonacci/Lucas series generator. It samples a binary series value, converts it to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low seven-segment display with optional leading-zero blanking. The generator's `led_on` (or any strobe) feeds `in_valid`. A value that arrives while a conversion is in progress is dropped by design.

## Interface

Parameters:

- `WIDTH`, 16: binary input width. Matches the generator's output width.
- `DIGITS`, 5: BCD digits. Must be ≥ ceil(WIDTH·log10 2); 5 covers 65535.
- `SCAN_DIV`, 1000: clocks per displayed digit. Must be ≥ 1.
- `BLANK_LZ`, 1: 1 = blank leading zeros; digit 0 is never blanked.

Ports:

- `clk`  in  1: single clock, all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_value`  in  WIDTH: binary value to convert.
- `in_valid`  in  1: sample request.
- `in_ready`  out  1: high only in IDLE. A sample is accepted on an edge where `in_valid & in_ready`.
- `bcd_out`  out  4·DIGITS: packed BCD; nibble 0 is the units digit. Holds until the next completion.
- `bcd_valid`  out  1: one-cycle pulse when `bcd_out` updates.
- `seg_n`  out  7: active-low cathodes. Bit 0 = a … bit 6 = g.
- `an_n`  out  DIGITS: active-low anodes, one-hot low while scanning.

## Operation

- Converter FSM states:
  - IDLE: `in_ready` = 1. On accept, load the shift register with `in_value`, clear the BCD scratch, load the bit counter with WIDTH, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, shift register} left by 1. Decrement the counter. After WIDTH shifts, go to DONE.
  - DONE: copy scratch to `bcd_out`, assert `bcd_valid`, return to IDLE.
- While not in IDLE, `in_valid` is ignored and values are not queued.
- Display path:
  - A prescaler counts 0..SCAN_DIV−1. On its terminal count, the digit index advances 0→DIGITS−1 and wraps to 0.
  - `an_n` = ~(1 << index).
  - `seg_n` = decode of the `bcd_out` nibble at that index. Codes 0–9 use the standard patterns, e.g. '0' = 7'b1000000 and '1' = 7'b1111001. Codes 10–15 decode to blank (7'h7F).
  - Blanking (BLANK_LZ = 1): a digit above the highest nonzero nibble shows 7'h7F with its anode still driven. Index 0 always shows its value.
  - `an_n` and `seg_n` are registered and change on the same edge.
- Reset values:
  - FSM = IDLE, so `in_ready` = 1 while `reset_n` is low and after release.
  - `bcd_out` = 0, `bcd_valid` = 0.
  - `an_n` = all ones, `seg_n` = 7'h7F.
  - Prescaler = 0, index = 0.

## Timing

- Accept edge N. Shifts occur on edges N+1 … N+WIDTH. `bcd_out` loads on edge N+WIDTH+1. `bcd_valid` is high for exactly the cycle after that edge, and `in_ready` is high in that same cycle.
- Latency is WIDTH+1 edges (17 for WIDTH = 16). Minimum accept-to-accept spacing is WIDTH+2 cycles (18).
- Simultaneous `bcd_valid` and new accept is legal. The new conversion starts and the old `bcd_out` holds until the next completion.
- After reset release, the first display update occurs at the first prescaler terminal count, i.e. edge SCAN_DIV. Before that, the display is dark.
- A new `bcd_out` is reflected on the next scan edge; the scan position is not reset.
- Asserting `reset_n` mid-conversion aborts immediately: no `bcd_valid`, all outputs at reset values. The next accept after release converts correctly.
- Arithmetic: each add-3 is a 4-bit unsigned add on a nibble ≥ 5 and cannot carry. No saturation is needed given the DIGITS constraint.

## Test plan

- Reset, then accept 46368 at edge N → `bcd_out` = 20'h46368 at edge N+17, `bcd_valid` high for one cycle, `in_ready` low for 17 cycles.
- Accept 0 and then 65535 → 20'h00000 and then 20'h65535. `bcd_valid` pulses twice, 18 cycles apart if accepts are back-to-back.
- Hold `in_valid` high with `in_value` incrementing each cycle from 0 → only the values present on accept edges (0, 18, 36, …) are converted, and those results appear as BCD.
- Assert `reset_n` low at edge N+5 of a conversion of 1597 → outputs go to reset values immediately and no `bcd_valid` occurs. A subsequent accept of 1597 yields 20'h01597.
- SCAN_DIV = 4, `bcd_out` = 20'h00144, BLANK_LZ = 1 → `an_n` steps 11110→11101→11011→10111→01111 every 4 clocks. `seg_n` shows 4, 4, 1, then 7'h7F, 7'h7F.
- SCAN_DIV = 4, `bcd_out` = 0, BLANK_LZ = 0 → all five digits show 7'b1000000. With BLANK_LZ = 1, only digit 0 shows '0'.
